// File: rtl/movsum_pkg.sv
// Shared types and width helpers for the movsum boxcar filter.
// Width functions are elaboration-time only; they size the sum and fill counter.
package movsum_pkg;

    typedef enum logic {FILL, RUN} movsum_state_t;

    function automatic int swidth(input int width, input int window);
        return width + $clog2(window);
    endfunction

    function automatic int cntwidth(input int window);
        int c;
        c = $clog2(window);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/movsum.sv
// Boxcar moving-sum filter fed by a delay line of length WINDOW.
// Fills the window from zero first, then adds the newest and subtracts the departing sample.
module movsum
    import movsum_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 4,
    parameter int SIGNED = 1,
    localparam int SWIDTH = swidth(WIDTH, WINDOW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              clr,
    input  logic [WIDTH-1:0]  data,
    input  logic [WIDTH-1:0]  delayed,
    output logic [SWIDTH-1:0] sum,
    output logic [WIDTH-1:0]  mean,
    output logic              valid,
    output logic              strobe
);

    localparam int SH = $clog2(WINDOW);
    localparam int CW = cntwidth(WINDOW);

    if (WINDOW < 1) begin : g_window_check
        $error("movsum: WINDOW must be >= 1");
    end

    movsum_state_t      state_q, state_d;
    logic [SWIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]      fill_cnt_q, fill_cnt_d;
    logic [WIDTH-1:0]   mean_q, mean_d;
    logic               valid_q, valid_d;
    logic               strobe_q, strobe_d;

    logic [SWIDTH-1:0]        data_ext, delayed_ext;
    logic signed [SWIDTH-1:0] acc_next_s;
    logic [SWIDTH-1:0]        mean_wide;

    always_comb begin
        if (SIGNED != 0) begin
            data_ext    = SWIDTH'($signed(data));
            delayed_ext = SWIDTH'($signed(delayed));
        end else begin
            data_ext    = SWIDTH'(data);
            delayed_ext = SWIDTH'(delayed);
        end
    end

    // Mean tracks the next accumulator so both update on the same edge.
    always_comb begin
        acc_next_s = acc_d;
        if (SIGNED != 0) begin
            mean_wide = acc_next_s >>> SH;
        end else begin
            mean_wide = acc_d >> SH;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        fill_cnt_d = fill_cnt_q;
        valid_d    = valid_q;
        mean_d     = mean_q;
        strobe_d   = 1'b0;

        if (clr) begin
            state_d    = FILL;
            acc_d      = '0;
            fill_cnt_d = '0;
            valid_d    = 1'b0;
            mean_d     = '0;
        end else if (ena) begin
            if (state_q == FILL) begin
                // The delay line still holds stale content while filling.
                acc_d      = acc_q + data_ext;
                fill_cnt_d = fill_cnt_q + CW'(1);
                if (fill_cnt_q == CW'(WINDOW - 1)) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end else begin
                acc_d = acc_q + data_ext - delayed_ext;
            end
            mean_d   = WIDTH'(mean_wide);
            strobe_d = valid_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= FILL;
            acc_q      <= '0;
            fill_cnt_q <= '0;
            mean_q     <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fill_cnt_q <= fill_cnt_d;
            mean_q     <= mean_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
        end
    end

    assign sum    = acc_q;
    assign mean   = mean_q;
    assign valid  = valid_q;
    assign strobe = strobe_q;

endmodule
